// File: rtl/rmem_pkg.sv
// Shared definitions for the load/memory controller: funct3 load encodings,
// FSM state enum and small decode helpers used by the controller.
package rmem_pkg;

  // funct3 encodings of the supported loads
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ0 = 2'd1,
    REQ1 = 2'd2,
    DONE = 2'd3
  } rmem_state_t;

  // True for the five load encodings this block understands
  function automatic logic type_valid(input logic [2:0] t);
    return (t == LD_LB) || (t == LD_LH) || (t == LD_LW) ||
           (t == LD_LBU) || (t == LD_LHU);
  endfunction

  // Halfwords need an even address, words a multiple of four
  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
    return (((t == LD_LH) || (t == LD_LHU)) && off[0]) ||
           ((t == LD_LW) && (off != 2'b00));
  endfunction

  // Access whose bytes spill into the following word
  function automatic logic crosses_word(input logic [2:0] t, input logic [1:0] off);
    return ((t == LD_LW) && (off != 2'b00)) ||
           (((t == LD_LH) || (t == LD_LHU)) && (off == 2'b11));
  endfunction

endpackage

// File: rtl/rmem_load_extract.sv
// Byte/halfword/word selection and sign/zero extension of a load result.
// 'merged' holds {second word, first word}; single-word loads put zeros on top.
module load_extract
  import rmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] merged,
  input  logic [1:0]        offset,
  input  logic [2:0]        ld_type,
  output logic [XLEN-1:0]   result
);

  logic [31:0] win;

  // Shift the addressed byte down to bit 0, then truncate and extend per type
  always_comb begin
    win    = 32'(merged >> {offset, 3'b000});
    result = '0;
    case (ld_type)
      LD_LB:   result = XLEN'($signed(win[7:0]));
      LD_LH:   result = XLEN'($signed(win[15:0]));
      LD_LW:   result = XLEN'($signed(win[31:0]));
      LD_LBU:  result = XLEN'(win[7:0]);
      LD_LHU:  result = XLEN'(win[15:0]);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rmem_control.sv
// Load controller between the MEM stage and a word-wide data memory.
// Optional feature: define RMEM_MISALIGNED_LOAD_EN to service misaligned
// loads in hardware (two reads for word-crossing accesses); otherwise they
// are answered at once with rsp_misalign = 1 and no memory access.
module rmem_control
  import rmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [2:0]      ld_type,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_misalign,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

`ifdef RMEM_MISALIGNED_LOAD_EN
  localparam logic MisalignedEn = 1'b1;
`else
  localparam logic MisalignedEn = 1'b0;
`endif

  rmem_state_t     state_reg;
  logic [1:0]      off_reg;
  logic [2:0]      type_reg;
  logic [XLEN-1:0] w0_reg;
  logic            ld_ready_reg;
  logic            busy_reg;
  logic            mem_req_reg;
  logic [XLEN-1:0] mem_addr_reg;
  logic            rsp_valid_reg;
  logic [XLEN-1:0] rsp_data_reg;
  logic            rsp_misalign_reg;

  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   extracted;
  logic              second_word;
  logic              reject;

  // Merge the captured first word with the live read data; decode accept/second-read needs
  always_comb begin
    merged      = (state_reg == REQ1) ? {mem_rdata, w0_reg} : {{XLEN{1'b0}}, mem_rdata};
    second_word = MisalignedEn && crosses_word(type_reg, off_reg);
    reject      = !type_valid(ld_type) ||
                  (is_misaligned(ld_type, ld_addr[1:0]) && !MisalignedEn);
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .merged  (merged),
    .offset  (off_reg),
    .ld_type (type_reg),
    .result  (extracted)
  );

  // Controller FSM; every output is a register updated together with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      off_reg          <= '0;
      type_reg         <= '0;
      w0_reg           <= '0;
      ld_ready_reg     <= 1'b1;
      busy_reg         <= 1'b0;
      mem_req_reg      <= 1'b0;
      mem_addr_reg     <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_data_reg     <= '0;
      rsp_misalign_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ld_valid) begin
            off_reg      <= ld_addr[1:0];
            type_reg     <= ld_type;
            ld_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            if (reject) begin
              // Invalid type or unsupported misalignment: answer without memory
              state_reg        <= DONE;
              rsp_valid_reg    <= 1'b1;
              rsp_data_reg     <= '0;
              rsp_misalign_reg <= type_valid(ld_type);
            end else begin
              state_reg    <= REQ0;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= {ld_addr[XLEN-1:2], 2'b00};
            end
          end
        end
        REQ0: begin
          if (mem_ack) begin
            if (second_word) begin
              state_reg    <= REQ1;
              w0_reg       <= mem_rdata;
              mem_addr_reg <= mem_addr_reg + XLEN'(4);
            end else begin
              state_reg        <= DONE;
              mem_req_reg      <= 1'b0;
              rsp_valid_reg    <= 1'b1;
              rsp_data_reg     <= extracted;
              rsp_misalign_reg <= 1'b0;
            end
          end
        end
        REQ1: begin
          if (mem_ack) begin
            state_reg        <= DONE;
            mem_req_reg      <= 1'b0;
            rsp_valid_reg    <= 1'b1;
            rsp_data_reg     <= extracted;
            rsp_misalign_reg <= 1'b0;
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
          ld_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ld_ready     = ld_ready_reg;
  assign busy         = busy_reg;
  assign mem_req      = mem_req_reg;
  assign mem_addr     = mem_addr_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = rsp_data_reg;
  assign rsp_misalign = rsp_misalign_reg;

endmodule

// File: tb/tb_rmem_control.sv
// Directed bench for rmem_control with a response scoreboard.
// Build with +define+RMEM_MISALIGNED_LOAD_EN to cover hardware misaligned loads.
module tb_rmem_control;
  import rmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_type = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_misalign;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] sb_q[$];

  rmem_control #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_type      (ld_type),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_misalign (rsp_misalign),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s: observed 0x%08h expected 0x%08h", tag, what, obs, exp);
    end
  endtask

  // Pop the oldest expected response and compare it to the DUT output
  task automatic sb_check(input string tag);
    logic [32:0] e;
    if (sb_q.size() == 0) begin
      chk(tag, "sb_unexpected_rsp", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk(tag, "rsp_data", rsp_data, e[31:0]);
      chk(tag, "rsp_misalign", 32'(rsp_misalign), 32'(e[32]));
    end
  endtask

  // One load: accept, serve up to two reads with wait_cyc idle cycles before each ack,
  // then check the response against the scoreboard and its latency from accept.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] typ,
                          input int n_acc, input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1, input int wait_cyc,
                          input int exp_lat, input logic [31:0] exp_data, input logic exp_mis);
    int lat, acc, waited;
    bit got;
    chk(tag, "ld_ready_idle", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_type  = typ;
    sb_q.push_back({exp_mis, exp_data});
    tick();
    ld_valid = 1'b0;
    lat = 1; acc = 0; waited = 0; got = 0;
    while (!got && lat < 50) begin
      chk(tag, "busy", 32'(busy), 32'd1);
      chk(tag, "ld_ready_busy", 32'(ld_ready), 32'd0);
      if (rsp_valid) begin
        got = 1;
        sb_check(tag);
        chk(tag, "latency", 32'(lat), 32'(exp_lat));
        chk(tag, "accesses", 32'(acc), 32'(n_acc));
        chk(tag, "mem_req_done", 32'(mem_req), 32'd0);
      end else begin
        if (mem_req) begin
          if (acc >= n_acc) begin
            chk(tag, "unexpected_mem_req", 32'd1, 32'd0);
          end else begin
            chk(tag, "mem_addr", mem_addr, (acc == 0) ? a0 : a1);
            if (waited == wait_cyc) begin
              mem_ack   = 1'b1;
              mem_rdata = (acc == 0) ? d0 : d1;
              acc++;
              waited = 0;
            end else begin
              waited++;
            end
          end
        end
        tick();
        mem_ack = 1'b0;
        lat++;
      end
    end
    if (!got) chk(tag, "rsp_timeout", 32'(lat), 32'(exp_lat));
    tick();
    chk(tag, "rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk(tag, "busy_after", 32'(busy), 32'd0);
    chk(tag, "ld_ready_after", 32'(ld_ready), 32'd1);
    chk(tag, "rsp_data_hold", rsp_data, exp_data);
    $display("load %s addr=0x%08h type=%0d -> data=0x%08h misalign=%0d lat=%0d",
             tag, addr, typ, rsp_data, rsp_misalign, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts, resps;

    // Reset state
    tick();
    tick();
    chk("reset", "ld_ready", 32'(ld_ready), 32'd1);
    chk("reset", "busy", 32'(busy), 32'd0);
    chk("reset", "mem_req", 32'(mem_req), 32'd0);
    chk("reset", "mem_addr", mem_addr, 32'd0);
    chk("reset", "rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset", "rsp_data", rsp_data, 32'd0);
    chk("reset", "rsp_misalign", 32'(rsp_misalign), 32'd0);
    rst_n = 1'b1;
    tick();

    // Aligned and sub-word loads
    run_load("lb_1003", 32'h1003, LD_LB, 1, 32'h1000, 32'h80FF_1234, 0, 0, 0, 2, 32'hFFFF_FF80, 1'b0);
    run_load("lhu_2002_wait3", 32'h2002, LD_LHU, 1, 32'h2000, 32'h9ABC_5678, 0, 0, 3, 5, 32'h0000_9ABC, 1'b0);
    run_load("lbu_1003", 32'h1003, LD_LBU, 1, 32'h1000, 32'h80FF_1234, 0, 0, 0, 2, 32'h0000_0080, 1'b0);
    run_load("lb_1000", 32'h1000, LD_LB, 1, 32'h1000, 32'h80FF_1234, 0, 0, 0, 2, 32'h0000_0034, 1'b0);
    run_load("lb_1002", 32'h1002, LD_LB, 1, 32'h1000, 32'h80FF_1234, 0, 0, 0, 2, 32'hFFFF_FFFF, 1'b0);
    run_load("lh_2002", 32'h2002, LD_LH, 1, 32'h2000, 32'h9ABC_5678, 0, 0, 0, 2, 32'hFFFF_9ABC, 1'b0);
    run_load("lhu_2000_wait1", 32'h2000, LD_LHU, 1, 32'h2000, 32'h9ABC_5678, 0, 0, 1, 3, 32'h0000_5678, 1'b0);
    run_load("lw_3000", 32'h3000, LD_LW, 1, 32'h3000, 32'hCAFE_F00D, 0, 0, 0, 2, 32'hCAFE_F00D, 1'b0);

    // Invalid types: no memory access, zero data, no misalign flag
    run_load("type011", 32'h5003, 3'b011, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1'b0);
    run_load("type110", 32'h5001, 3'b110, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1'b0);
    run_load("type111", 32'h5000, 3'b111, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1'b0);

    // Misaligned loads
`ifdef RMEM_MISALIGNED_LOAD_EN
    run_load("lw_3001", 32'h3001, LD_LW, 2, 32'h3000, 32'h4433_2211, 32'h3004, 32'h8877_6655, 0, 3, 32'h5544_3322, 1'b0);
    run_load("lh_2001", 32'h2001, LD_LH, 1, 32'h2000, 32'h9ABC_5678, 0, 0, 0, 2, 32'hFFFF_BC56, 1'b0);
    run_load("lhu_2003", 32'h2003, LD_LHU, 2, 32'h2000, 32'h9ABC_5678, 32'h2004, 32'h1122_33EE, 0, 3, 32'h0000_EE9A, 1'b0);
    run_load("lw_wrap", 32'hFFFF_FFFF, LD_LW, 2, 32'hFFFF_FFFC, 32'h1122_3344, 32'h0000_0000, 32'h5566_7788, 1, 5, 32'h6677_8811, 1'b0);
`else
    run_load("lw_3001", 32'h3001, LD_LW, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1'b1);
    run_load("lh_2001", 32'h2001, LD_LH, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1'b1);
    run_load("lhu_2003", 32'h2003, LD_LHU, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1'b1);
    run_load("lw_wrap", 32'hFFFF_FFFF, LD_LW, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1'b1);
`endif

    // Leave a nonzero rsp_data so the reset check below is meaningful
    run_load("lw_pre_rst", 32'h3000, LD_LW, 1, 32'h3000, 32'h1234_5678, 0, 0, 0, 2, 32'h1234_5678, 1'b0);

    // Reset while waiting for an ack, then a late ack that must be ignored
    ld_valid = 1'b1; ld_addr = 32'h4000; ld_type = LD_LW;
    tick();
    ld_valid = 1'b0;
    chk("rst_mid", "mem_req_wait1", 32'(mem_req), 32'd1);
    tick();
    chk("rst_mid", "mem_req_wait2", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", "ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_mid", "busy", 32'(busy), 32'd0);
    chk("rst_mid", "mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid", "mem_addr", mem_addr, 32'd0);
    chk("rst_mid", "rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid", "rsp_data", rsp_data, 32'd0);
    chk("rst_mid", "rsp_misalign", 32'(rsp_misalign), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack", "rsp_valid", 32'(rsp_valid), 32'd0);
      chk("late_ack", "mem_req", 32'(mem_req), 32'd0);
      chk("late_ack", "busy", 32'(busy), 32'd0);
      tick();
    end
    $display("reset mid-load: discarded, late ack ignored");
    run_load("lw_after_rst", 32'h4000, LD_LW, 1, 32'h4000, 32'hA1B2_C3D4, 0, 0, 0, 2, 32'hA1B2_C3D4, 1'b0);

    // ld_valid held high: each new accept only after the previous response
    accepts = 0; resps = 0;
    ld_valid = 1'b1; ld_addr = 32'h10; ld_type = LD_LW;
    for (int c = 0; c < 12; c++) begin
      if (ld_ready) begin
        chk("b2b", "outstanding_at_accept", 32'(sb_q.size()), 32'd0);
        sb_q.push_back({1'b0, 32'hA500_0010});
        accepts++;
      end
      if (rsp_valid) begin
        sb_check("b2b");
        resps++;
      end
      if (mem_req) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hA500_0000 | mem_addr;
      end
      tick();
      mem_ack  = 1'b0;
    end
    ld_valid = 1'b0;
    chk("b2b", "accepts", 32'(accepts), 32'd4);
    chk("b2b", "responses", 32'(resps), 32'd4);
    chk("b2b", "sb_drained", 32'(sb_q.size()), 32'd0);
    $display("back-to-back: accepts=%0d responses=%0d", accepts, resps);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
